key_loader_serial: RTL and testbench

//   Upstream feeder for the 16-key-input locked combinational netlists (keyinput0..keyinput15).
//   - Shifts a key plus checksum in serially from the on-chip key store, checks it, and only then drives the key bus.
//   - Key bus is forced to all-zero whenever no verified key is held; never exposes partial shift contents.
//   - The wrapper bit-blasts key_out[i] onto keyinput<i> of the locked netlist.

---
 rtl/key_pkg.sv | 27 ++
 rtl/key_chk_fold.sv | 20 ++
 rtl/key_loader_serial.sv | 120 ++++++++++++
 tb/tb_key_loader_serial.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared types and helpers for the serial key loader.
// Holds the loader state encoding and the default key/checksum widths.
package key_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        CHECK,
        HOLD,
        ERROR
    } key_ld_state_t;

    localparam int KEY_W_DEF = 16;
    localparam int CHK_W_DEF = 4;

    function automatic logic [CHK_W_DEF-1:0] chk_fold(
        input logic [KEY_W_DEF-1:0] key
    );
        logic [CHK_W_DEF-1:0] acc;
        acc = '0;
        for (int i = 0; i < KEY_W_DEF / CHK_W_DEF; i++) begin
            acc ^= key[i*CHK_W_DEF +: CHK_W_DEF];
        end
        return acc;
    endfunction

endpackage

// File: rtl/key_chk_fold.sv
// Combinational XOR-fold of a key into CHK_W-bit slices.
// Produces the checksum the loader compares against the shifted-in one.
module key_chk_fold
    import key_pkg::*;
#(
    parameter int KEY_W = KEY_W_DEF,
    parameter int CHK_W = CHK_W_DEF
) (
    input  logic [KEY_W-1:0] key,
    output logic [CHK_W-1:0] chk
);

    always_comb begin
        chk = '0;
        for (int i = 0; i < KEY_W / CHK_W; i++) begin
            chk ^= key[i*CHK_W +: CHK_W];
        end
    end

endmodule

// File: rtl/key_loader_serial.sv
// Serial key loader: shifts in key plus checksum, verifies it, then drives
// the key bus of the locked netlist. The bus stays zero unless a key is verified.
module key_loader_serial
    import key_pkg::*;
#(
    parameter int KEY_W = KEY_W_DEF,
    parameter int CHK_W = CHK_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sdi,
    input  logic             sdi_vld,
    output logic             sdi_rdy,
    input  logic             zeroize,
    output logic [KEY_W-1:0] key_out,
    output logic             key_valid,
    output logic             key_err,
    output logic             busy
);

    localparam int SH_W  = KEY_W + CHK_W;
    localparam int CNT_W = $clog2(SH_W + 1);

    key_ld_state_t    state, state_nxt;
    logic [SH_W-1:0]  shift_q, shift_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic             vld_q, vld_d;
    logic             err_q, err_d;
    logic [CHK_W-1:0] fold_chk;
    logic             chk_ok;
    logic             accept;

    key_chk_fold #(
        .KEY_W(KEY_W),
        .CHK_W(CHK_W)
    ) u_fold (
        .key(shift_q[SH_W-1:CHK_W]),
        .chk(fold_chk)
    );

    assign chk_ok  = (fold_chk == shift_q[CHK_W-1:0]);
    assign sdi_rdy = (state == SHIFT);
    assign accept  = sdi_vld && sdi_rdy;
    assign busy    = (state == SHIFT) || (state == CHECK);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            key_q   <= '0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_nxt = state;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        key_d     = key_q;
        vld_d     = vld_q;
        err_d     = err_q;
        if (zeroize) begin
            state_nxt = IDLE;
            shift_d   = '0;
            cnt_d     = '0;
            key_d     = '0;
            vld_d     = 1'b0;
            err_d     = 1'b0;
        end else if (start) begin
            // Any start drops the held key so it is never seen during a reload
            state_nxt = SHIFT;
            shift_d   = '0;
            cnt_d     = '0;
            key_d     = '0;
            vld_d     = 1'b0;
            err_d     = 1'b0;
        end else begin
            unique case (state)
                SHIFT: begin
                    if (accept) begin
                        shift_d = {shift_q[SH_W-2:0], sdi};
                        cnt_d   = cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(SH_W - 1)) begin
                            state_nxt = CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (chk_ok) begin
                        state_nxt = HOLD;
                        key_d     = shift_q[SH_W-1:CHK_W];
                        vld_d     = 1'b1;
                    end else begin
                        state_nxt = ERROR;
                        key_d     = '0;
                        vld_d     = 1'b0;
                        err_d     = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign key_out   = key_q;
    assign key_valid = vld_q;
    assign key_err   = err_q;

endmodule

// File: tb/tb_key_loader_serial.sv
// Self-checking bench for key_loader_serial.
// Expected load outcomes are queued at stimulus time and popped at completion.
module tb_key_loader_serial;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sdi;
    logic        sdi_vld;
    logic        sdi_rdy;
    logic        zeroize;
    logic [15:0] key_out;
    logic        key_valid;
    logic        key_err;
    logic        busy;

    typedef struct {
        logic [15:0] key;
        logic        vld;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    key_loader_serial dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sdi      (sdi),
        .sdi_vld  (sdi_vld),
        .sdi_rdy  (sdi_rdy),
        .zeroize  (zeroize),
        .key_out  (key_out),
        .key_valid(key_valid),
        .key_err  (key_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] ref_chk(input logic [15:0] k);
        return k[15:12] ^ k[11:8] ^ k[7:4] ^ k[3:0];
    endfunction

    // Sends bits [from, to) of the 20-bit word, MSB first
    task automatic send_bits(input logic [19:0] w, input int from,
                             input int to, input bit gate);
        int  idx;
        int  guard;
        logic rdy;
        idx   = from;
        guard = 0;
        while (idx < to && guard < 2000) begin
            sdi     = w[19-idx];
            sdi_vld = gate ? ($urandom_range(0, 3) != 0) : 1'b1;
            rdy     = sdi_rdy;
            tick();
            if (sdi_vld && rdy) idx++;
            guard++;
        end
        sdi_vld = 1'b0;
        if (idx < to) check("send_timeout", 32'(idx), 32'(to));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_load(input string tag, input logic [15:0] k,
                           input logic [3:0] c, input bit gate);
        exp_t e;
        exp_t got;
        bit   good;
        good  = (c == ref_chk(k));
        e.key = good ? k : 16'h0;
        e.vld = good;
        e.err = !good;
        sb.push_back(e);
        pulse_start();
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_rdy"}, 32'(sdi_rdy), 32'd1);
        send_bits({k, c}, 0, 20, gate);
        // One cycle in CHECK: nothing exposed yet
        check({tag, "_chk_vld"}, 32'(key_valid), 32'd0);
        check({tag, "_chk_key"}, 32'(key_out), 32'd0);
        check({tag, "_chk_rdy"}, 32'(sdi_rdy), 32'd0);
        tick();
        got = sb.pop_front();
        check({tag, "_key"}, 32'(key_out), 32'(got.key));
        check({tag, "_vld"}, 32'(key_valid), 32'(got.vld));
        check({tag, "_err"}, 32'(key_err), 32'(got.err));
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
        check({tag, "_rdy_end"}, 32'(sdi_rdy), 32'd0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_key"}, 32'(key_out), 32'd0);
        check({tag, "_vld"}, 32'(key_valid), 32'd0);
        check({tag, "_err"}, 32'(key_err), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_rdy"}, 32'(sdi_rdy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] k;
        logic [3:0]  c;
        rst     = 1'b1;
        start   = 1'b0;
        sdi     = 1'b0;
        sdi_vld = 1'b0;
        zeroize = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_idle("reset");

        // 1. good key
        do_load("good", 16'hA5C3, 4'h0, 1'b0);

        // 2. bad checksum
        do_load("bad", 16'h1234, 4'h5, 1'b0);

        // 3. stall then restart after bit 9
        pulse_start();
        check("restart_err_clr", 32'(key_err), 32'd0);
        send_bits({16'hFFFF, 4'h0}, 0, 5, 1'b0);
        repeat (7) tick();
        check("stall_busy", 32'(busy), 32'd1);
        check("stall_rdy", 32'(sdi_rdy), 32'd1);
        check("stall_vld", 32'(key_valid), 32'd0);
        send_bits({16'hFFFF, 4'h0}, 5, 9, 1'b0);
        do_load("restart", 16'h1234, 4'h4, 1'b0);

        // 4. reload from HOLD
        do_load("preload", 16'hA5C3, 4'h0, 1'b0);
        pulse_start();
        check("reload_key", 32'(key_out), 32'd0);
        check("reload_vld", 32'(key_valid), 32'd0);
        check("reload_busy", 32'(busy), 32'd1);
        do_load("reload", 16'h1234, 4'h4, 1'b0);

        // 5. zeroize and start together in HOLD
        zeroize = 1'b1;
        start   = 1'b1;
        tick();
        zeroize = 1'b0;
        start   = 1'b0;
        check_idle("zeroize_hold");
        do_load("zbad", 16'h00FF, 4'h1, 1'b0);
        zeroize = 1'b1;
        tick();
        zeroize = 1'b0;
        check_idle("zeroize_err");

        // zeroize wins over a bit accepted in the same cycle
        pulse_start();
        send_bits({16'h8001, 4'h0}, 0, 19, 1'b0);
        sdi     = 1'b0;
        sdi_vld = 1'b1;
        zeroize = 1'b1;
        tick();
        sdi_vld = 1'b0;
        zeroize = 1'b0;
        check_idle("zeroize_last");
        tick();
        check_idle("zeroize_last2");

        // 6. reset at bit 12, gated valid
        k = 16'h5A3C;
        pulse_start();
        send_bits({k, ref_chk(k)}, 0, 12, 1'b1);
        rst     = 1'b1;
        sdi_vld = 1'b1;
        tick();
        rst     = 1'b0;
        sdi_vld = 1'b0;
        check_idle("midrst");
        do_load("after_rst", k, ref_chk(k), 1'b1);

        // random loads, some with corrupted checksum
        for (int i = 0; i < 6; i++) begin
            k = 16'($urandom);
            c = ref_chk(k);
            if (i % 3 == 1) c = c ^ 4'(1 << (i % 4));
            do_load("rand", k, c, 1'b1);
        end

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
